// File: rtl/qam_tx_frame_ctrl.sv
// qam_tx_frame_ctrl
// Frame sequencer for the 16-QAM transmitter. Sits between the serial_2_parallel symbol packer
// and the mapper and emits frames of PREAMBLE, PAYLOAD, GUARD.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   start          level request to send a frame
//   sym_in         packed 4-bit symbol from serial_2_parallel
//   sym_valid      sym_in valid, single-cycle pulse
//   src_enable     enable to data_generator / serial_2_parallel (high during PAYLOAD)
//   sym_out        symbol to mapper
//   sym_out_valid  sym_out valid, single-cycle pulse
//   frame_sof      pulses with the first preamble symbol
//   frame_eof      pulses with the last payload symbol
//   busy           high in every state except IDLE
//   overrun        sticky flag: sym_valid seen outside PAYLOAD
//
// All outputs are registered; each output register is loaded from the next-state values so
// that an output reflects the state the FSM occupies during that same cycle.

module qam_tx_frame_ctrl #(
    parameter int unsigned PREAMBLE_LEN = 8,
    parameter int unsigned PAYLOAD_LEN  = 64,
    parameter int unsigned GUARD_LEN    = 4,
    parameter int unsigned SYM_PERIOD   = 32,
    parameter logic [3:0]  PRE_SYM_A    = 4'b0011,
    parameter logic [3:0]  PRE_SYM_B    = 4'b1100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] sym_in,
    input  logic       sym_valid,
    output logic       src_enable,
    output logic [3:0] sym_out,
    output logic       sym_out_valid,
    output logic       frame_sof,
    output logic       frame_eof,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned GUARD_CYC = GUARD_LEN * SYM_PERIOD;
    // One counter serves both the preamble symbol period and the guard interval.
    localparam int unsigned CW = $clog2(GUARD_CYC);
    // k must reach PREAMBLE_LEN in PREAMBLE and PAYLOAD_LEN-1 in PAYLOAD.
    localparam int unsigned K_LIM = (PREAMBLE_LEN + 1 > PAYLOAD_LEN) ? PREAMBLE_LEN + 1
                                                                      : PAYLOAD_LEN;
    localparam int unsigned KW = $clog2(K_LIM);

    localparam logic [CW-1:0] CTR_SYM_LAST   = CW'(SYM_PERIOD - 1);
    localparam logic [CW-1:0] CTR_GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [KW-1:0] K_PRE_END      = KW'(PREAMBLE_LEN);
    localparam logic [KW-1:0] K_PAY_LAST     = KW'(PAYLOAD_LEN - 1);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StPreamble = 2'd1;
    localparam logic [1:0] StPayload  = 2'd2;
    localparam logic [1:0] StGuard    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic [KW-1:0] k_q, k_d;

    logic       src_enable_d;
    logic [3:0] sym_out_d;
    logic       sym_out_valid_d;
    logic       frame_sof_d;
    logic       frame_eof_d;
    logic       busy_d;
    logic       overrun_d;

    always_comb begin
        state_d         = state_q;
        ctr_d           = ctr_q;
        k_d             = k_q;
        sym_out_d       = sym_out;
        sym_out_valid_d = 1'b0;
        frame_sof_d     = 1'b0;
        frame_eof_d     = 1'b0;
        overrun_d       = overrun;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StPreamble;
                    ctr_d     = '0;
                    k_d       = '0;
                    overrun_d = 1'b0;
                end
            end
            StPreamble: begin
                // k advances after the cycle that emitted symbol k.
                if (ctr_q == '0) begin
                    k_d = k_q + 1'b1;
                end
                if (ctr_q == CTR_SYM_LAST) begin
                    ctr_d = '0;
                    if (k_q == K_PRE_END) begin
                        state_d = StPayload;
                        k_d     = '0;
                    end
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            StPayload: begin
                if (sym_valid) begin
                    sym_out_d       = sym_in;
                    sym_out_valid_d = 1'b1;
                    if (k_q == K_PAY_LAST) begin
                        // The eof cycle is the first guard cycle.
                        frame_eof_d = 1'b1;
                        state_d     = StGuard;
                        ctr_d       = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StGuard: begin
                sym_out_d = 4'h0;
                if (ctr_q == CTR_GUARD_LAST) begin
                    if (start) begin
                        state_d   = StPreamble;
                        ctr_d     = '0;
                        k_d       = '0;
                        overrun_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A stray symbol wins over the clear from a simultaneous frame start.
        if (sym_valid && (state_q != StPayload)) begin
            overrun_d = 1'b1;
        end

        if ((state_d == StPreamble) && (ctr_d == '0)) begin
            sym_out_d       = k_d[0] ? PRE_SYM_B : PRE_SYM_A;
            sym_out_valid_d = 1'b1;
            frame_sof_d     = (k_d == '0);
        end

        src_enable_d = (state_d == StPayload);
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ctr_q         <= '0;
            k_q           <= '0;
            src_enable    <= 1'b0;
            sym_out       <= 4'h0;
            sym_out_valid <= 1'b0;
            frame_sof     <= 1'b0;
            frame_eof     <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            k_q           <= k_d;
            src_enable    <= src_enable_d;
            sym_out       <= sym_out_d;
            sym_out_valid <= sym_out_valid_d;
            frame_sof     <= frame_sof_d;
            frame_eof     <= frame_eof_d;
            busy          <= busy_d;
            overrun       <= overrun_d;
        end
    end

endmodule

// File: tb/tb_qam_tx_frame_ctrl.sv
// tb_qam_tx_frame_ctrl
// Self-checking bench for qam_tx_frame_ctrl. A behavioural model describes each frame by the
// cycle offset t from its sof cycle, the number of payload symbols forwarded and the cycle of
// the eof; every cycle the DUT outputs are compared against it. Directed frames pin the model
// with hand-computed literal expectations; a long randomized run follows.

module tb_qam_tx_frame_ctrl;

    localparam int PRE = 8;
    localparam int PAY = 64;
    localparam int GL  = 4;
    localparam int P   = 32;
    localparam int GC  = GL * P;
    localparam logic [3:0] SYM_A = 4'h3;
    localparam logic [3:0] SYM_B = 4'hC;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] sym_in;
    logic       sym_valid;
    logic       src_enable;
    logic [3:0] sym_out;
    logic       sym_out_valid;
    logic       frame_sof;
    logic       frame_eof;
    logic       busy;
    logic       overrun;

    qam_tx_frame_ctrl #(
        .PREAMBLE_LEN (PRE),
        .PAYLOAD_LEN  (PAY),
        .GUARD_LEN    (GL),
        .SYM_PERIOD   (P),
        .PRE_SYM_A    (SYM_A),
        .PRE_SYM_B    (SYM_B)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sym_in        (sym_in),
        .sym_valid     (sym_valid),
        .src_enable    (src_enable),
        .sym_out       (sym_out),
        .sym_out_valid (sym_out_valid),
        .frame_sof     (frame_sof),
        .frame_eof     (frame_eof),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int eof_total = 0;
    bit chk_on = 1'b0;
    bit log_on = 1'b0;

    int         vcyc[$];
    logic [3:0] vval[$];
    int         sofc[$];
    int         eofc[$];

    // Model state: frame active, offset from sof cycle, payload count, eof offset (-1 = none).
    bit         m_act = 1'b0;
    int         m_t   = 0;
    int         m_pay = 0;
    int         m_g0  = -1;
    logic       m_ovr = 1'b0;
    logic [3:0] m_sym = 4'h0;

    logic       e_src = 1'b0, e_val = 1'b0, e_sof = 1'b0, e_eof = 1'b0, e_busy = 1'b0;
    logic       e_ovr = 1'b0;
    logic [3:0] e_sym = 4'h0;
    logic       n_src, n_val, n_sof, n_eof, n_busy, n_ovr;
    logic [3:0] n_sym;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc_n, act, exp);
        end
    endtask

    task automatic lchk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance the model by one clock given the inputs the DUT samples at that edge.
    function automatic void model_step(input bit r, input bit st, input bit v,
                                       input logic [3:0] d);
        bit in_pay;
        bit new_frame;
        bit fwd;
        n_val = 1'b0;
        n_sof = 1'b0;
        n_eof = 1'b0;
        fwd   = 1'b0;
        if (r) begin
            m_act = 1'b0;
            m_t   = 0;
            m_pay = 0;
            m_g0  = -1;
            m_ovr = 1'b0;
            m_sym = 4'h0;
        end else begin
            in_pay    = m_act && (m_t >= PRE * P) && (m_g0 < 0);
            new_frame = 1'b0;
            if (!m_act) begin
                new_frame = st;
            end else if ((m_g0 >= 0) && (m_t - m_g0 == GC - 1)) begin
                if (st) new_frame = 1'b1;
                else m_act = 1'b0;
            end else begin
                m_t++;
                if (in_pay && v) begin
                    fwd   = 1'b1;
                    n_val = 1'b1;
                    m_sym = d;
                    m_pay++;
                    if (m_pay == PAY) begin
                        m_g0  = m_t;
                        n_eof = 1'b1;
                    end
                end
            end
            if (new_frame) m_ovr = 1'b0;
            if (v && !in_pay) m_ovr = 1'b1;
            if (new_frame) begin
                m_act = 1'b1;
                m_t   = 0;
                m_pay = 0;
                m_g0  = -1;
            end
            if (m_act && !fwd && (m_t < PRE * P) && (m_t % P == 0)) begin
                n_val = 1'b1;
                n_sof = (m_t == 0);
                m_sym = ((m_t / P) % 2 == 1) ? SYM_B : SYM_A;
            end else if (m_act && (m_g0 >= 0) && (m_t > m_g0)) begin
                m_sym = 4'h0;
            end
        end
        n_sym  = m_sym;
        n_ovr  = m_ovr;
        n_busy = m_act;
        n_src  = m_act && (m_t >= PRE * P) && (m_g0 < 0);
    endfunction

    task automatic step(input bit r, input bit st, input bit v, input logic [3:0] d);
        rst       = r;
        start     = st;
        sym_valid = v;
        sym_in    = d;
        model_step(r, st, v, d);
        @(posedge clk);
        e_src  = n_src;
        e_val  = n_val;
        e_sof  = n_sof;
        e_eof  = n_eof;
        e_busy = n_busy;
        e_ovr  = n_ovr;
        e_sym  = n_sym;
        cyc_n++;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("src_enable", {3'b0, src_enable}, {3'b0, e_src});
            chk("sym_out", sym_out, e_sym);
            chk("sym_out_valid", {3'b0, sym_out_valid}, {3'b0, e_val});
            chk("frame_sof", {3'b0, frame_sof}, {3'b0, e_sof});
            chk("frame_eof", {3'b0, frame_eof}, {3'b0, e_eof});
            chk("busy", {3'b0, busy}, {3'b0, e_busy});
            chk("overrun", {3'b0, overrun}, {3'b0, e_ovr});
            if (frame_eof === 1'b1) eof_total++;
            if (log_on) begin
                if (sym_out_valid === 1'b1) begin
                    vcyc.push_back(cyc_n);
                    vval.push_back(sym_out);
                end
                if (frame_sof === 1'b1) sofc.push_back(cyc_n);
                if (frame_eof === 1'b1) eofc.push_back(cyc_n);
            end
        end
    end

    initial begin
        int n;
        int e0;
        bit v;
        logic [3:0] exp_sym;

        chk_on = 1'b1;
        // Reset and quiet idle.
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        lchk("rst_busy", int'(busy), 0);
        lchk("rst_sym_out", int'(sym_out), 0);
        lchk("rst_overrun", int'(overrun), 0);
        repeat (100) step(1'b0, 1'b0, 1'b0, 4'h0);
        lchk("idle_busy", int'(busy), 0);
        lchk("idle_src_enable", int'(src_enable), 0);

        // Two back-to-back frames: start held until the second sof, then dropped.
        log_on = 1'b1;
        step(1'b0, 1'b1, 1'b0, 4'h0);
        n = 0;
        while (sofc.size() < 2 && n < 3000) begin
            v = e_src && (n % 4 == 0);
            step(1'b0, 1'b1, v, 4'($urandom));
            n++;
        end
        lchk("sof_count", sofc.size(), 2);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            v = e_src && (n % 4 == 0);
            step(1'b0, 1'b0, v, 4'($urandom));
            n++;
        end
        lchk("idle_after_frame2", int'(busy), 0);
        log_on = 1'b0;

        lchk("pulse_count", vval.size(), 2 * (PRE + PAY));
        lchk("eof_count", eofc.size(), 2);
        if (vval.size() >= PRE + PAY && eofc.size() >= 1 && sofc.size() >= 2) begin
            for (int i = 0; i < PRE; i++) begin
                exp_sym = (i % 2 == 1) ? 4'hC : 4'h3;
                lchk($sformatf("pre_val_%0d", i), int'(vval[i]), int'(exp_sym));
            end
            for (int i = 0; i < PRE - 1; i++) begin
                lchk($sformatf("pre_gap_%0d", i), vcyc[i + 1] - vcyc[i], 32);
            end
            lchk("sof_on_first_pulse", sofc[0], vcyc[0]);
            lchk("payload_after_preamble", int'(vcyc[PRE] - sofc[0] > 256), 1);
            lchk("eof_on_64th", eofc[0], vcyc[PRE + PAY - 1]);
            lchk("guard_to_next_sof", sofc[1] - eofc[0], 128);
        end

        // Stray symbol in preamble sets a sticky overrun; next start clears it.
        step(1'b0, 1'b1, 1'b0, 4'h0);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            v = (n == 40) ? 1'b1 : (e_src && (n % 4 == 0));
            step(1'b0, 1'b0, v, 4'($urandom));
            if (frame_eof === 1'b1) lchk("overrun_at_eof", int'(overrun), 1);
            n++;
        end
        lchk("overrun_sticky_idle", int'(overrun), 1);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        lchk("overrun_cleared", int'(overrun), 0);
        lchk("busy_after_start", int'(busy), 1);

        // Reset during payload after 20 symbols abandons the frame.
        n = 0;
        while (m_pay < 20 && n < 3000) begin
            v = e_src && (n % 4 == 0);
            step(1'b0, 1'b0, v, 4'($urandom));
            n++;
        end
        e0 = eof_total;
        step(1'b1, 1'b0, 1'b0, 4'h0);
        lchk("midrst_busy", int'(busy), 0);
        lchk("midrst_valid", int'(sym_out_valid), 0);
        lchk("midrst_sym_out", int'(sym_out), 0);
        repeat (300) step(1'b0, 1'b0, 1'b0, 4'h0);
        lchk("midrst_no_eof", eof_total - e0, 0);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            v = e_src && (n % 3 == 0);
            step(1'b0, 1'b0, v, 4'($urandom));
            n++;
        end
        lchk("fresh_frame_eof", eof_total - e0, 1);

        // Randomized traffic, including stray symbols, start noise and rare resets.
        repeat (20000) begin
            bit r;
            bit st;
            r  = ($urandom_range(0, 2999) == 0);
            st = ($urandom_range(0, 7) == 0);
            v  = e_src ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
            step(r, st, v, 4'($urandom));
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
